// File: rtl/r5p_soc_gpio_irq.sv
// GPIO controller for the r5p SoC peripheral bus. It provides atomic set/clear of the outputs, byte-enabled
// register writes, and per-pin rise/fall capture into a W1C STATUS register that drives a level irq.
module r5p_soc_gpio_irq #(
    parameter int GW = 32,
    parameter int SW = 2,
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            bus_vld_i,
    input  logic            bus_wen_i,
    input  logic [AW-1:0]   bus_adr_i,
    input  logic [DW/8-1:0] bus_ben_i,
    input  logic [DW-1:0]   bus_wdt_i,
    output logic [DW-1:0]   bus_rdt_o,
    output logic            bus_rdy_o,
    output logic [GW-1:0]   gpio_o,
    output logic [GW-1:0]   gpio_e_o,
    input  logic [GW-1:0]   gpio_i,
    output logic            irq_o
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(SW + 2);
    localparam int IW = AW - 2;

    localparam logic [IW-1:0] A_OUT    = IW'(0);
    localparam logic [IW-1:0] A_OE     = IW'(1);
    localparam logic [IW-1:0] A_IN     = IW'(2);
    localparam logic [IW-1:0] A_SET    = IW'(3);
    localparam logic [IW-1:0] A_CLR    = IW'(4);
    localparam logic [IW-1:0] A_IEN    = IW'(5);
    localparam logic [IW-1:0] A_RISE   = IW'(6);
    localparam logic [IW-1:0] A_FALL   = IW'(7);
    localparam logic [IW-1:0] A_STATUS = IW'(8);

    logic [IW-1:0]         wordIdx;
    logic                  wrAcc;
    logic                  rdAcc;
    logic [DW-1:0]         beMask;
    logic [GW-1:0]         wrMask;
    logic [GW-1:0]         wrData;
    logic [GW-1:0]         w1cMask;
    logic [DW-1:0]         rdData;
    logic                  unusedBits;

    logic [SW-1:0][GW-1:0] sync_q;
    logic [GW-1:0]         prev_q;
    logic [GW-1:0]         syncVal;
    logic [GW-1:0]         riseEv;
    logic [GW-1:0]         fallEv;
    logic [GW-1:0]         capture;
    logic [CW-1:0]         guardCnt_q;
    logic                  guardDone;

    logic [GW-1:0]         out_q, out_d;
    logic [GW-1:0]         oe_q, oe_d;
    logic [GW-1:0]         ien_q, ien_d;
    logic [GW-1:0]         rise_q, rise_d;
    logic [GW-1:0]         fall_q, fall_d;
    logic [GW-1:0]         status_q, status_d;
    logic [DW-1:0]         rdt_q;

    assign bus_rdy_o = 1'b1;
    assign wordIdx   = bus_adr_i[AW-1:2];
    assign wrAcc     = bus_vld_i & bus_rdy_o & bus_wen_i;
    assign rdAcc     = bus_vld_i & bus_rdy_o & ~bus_wen_i;

    always_comb begin
        beMask = '0;
        for (int b = 0; b < BW; b++) begin
            beMask[b*8 +: 8] = {8{bus_ben_i[b]}};
        end
    end

    assign wrMask     = beMask[GW-1:0];
    assign wrData     = bus_wdt_i[GW-1:0] & wrMask;
    assign unusedBits = ^{bus_adr_i[1:0], bus_wdt_i, beMask};

    // Input synchronizer; prev_q is one cycle behind the synchronized value for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SW-2:0], gpio_i};
            prev_q <= sync_q[SW-1];
        end
    end

    assign syncVal = sync_q[SW-1];
    assign riseEv  = syncVal & ~prev_q;
    assign fallEv  = ~syncVal & prev_q;

    // Pins already high at reset would otherwise appear as rising edges once they reach the sync output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            guardCnt_q <= '0;
        end else if (!guardDone) begin
            guardCnt_q <= guardCnt_q + CW'(1);
        end
    end

    assign guardDone = (guardCnt_q == CW'(SW + 1));
    assign capture   = guardDone ? ((riseEv & rise_q) | (fallEv & fall_q)) : '0;

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        ien_d   = ien_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        w1cMask = '0;
        if (wrAcc) begin
            case (wordIdx)
                A_OUT:    out_d   = (out_q & ~wrMask) | wrData;
                A_OE:     oe_d    = (oe_q & ~wrMask) | wrData;
                A_SET:    out_d   = out_q | wrData;
                A_CLR:    out_d   = out_q & ~wrData;
                A_IEN:    ien_d   = (ien_q & ~wrMask) | wrData;
                A_RISE:   rise_d  = (rise_q & ~wrMask) | wrData;
                A_FALL:   fall_d  = (fall_q & ~wrMask) | wrData;
                A_STATUS: w1cMask = wrData;
                default:  ;
            endcase
        end
        // A new capture beats a simultaneous W1C on the same bit.
        status_d = (status_q & ~w1cMask) | capture;
    end

    always_comb begin
        rdData = '0;
        case (wordIdx)
            A_OUT:    rdData[GW-1:0] = out_q;
            A_OE:     rdData[GW-1:0] = oe_q;
            A_IN:     rdData[GW-1:0] = syncVal;
            A_IEN:    rdData[GW-1:0] = ien_q;
            A_RISE:   rdData[GW-1:0] = rise_q;
            A_FALL:   rdData[GW-1:0] = fall_q;
            A_STATUS: rdData[GW-1:0] = status_q;
            default:  rdData = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q    <= '0;
            oe_q     <= '0;
            ien_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            rdt_q    <= '0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            ien_q    <= ien_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            if (rdAcc) begin
                rdt_q <= rdData;
            end
        end
    end

    assign bus_rdt_o = rdt_q;
    assign gpio_o    = out_q;
    assign gpio_e_o  = oe_q;
    assign irq_o     = |(status_q & ien_q);

endmodule

// File: tb/tb_r5p_soc_gpio_irq.sv
// Self-checking bench for r5p_soc_gpio_irq: directed scenarios followed by random bus/pin traffic,
// all compared against a pin-history reference model of the register map.
module tb_r5p_soc_gpio_irq;

    localparam int GW = 32;
    localparam int SW = 2;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bus_vld;
    logic          bus_wen;
    logic [AW-1:0] bus_adr;
    logic [3:0]    bus_ben;
    logic [31:0]   bus_wdt;
    logic [31:0]   bus_rdt;
    logic          bus_rdy;
    logic [31:0]   gpio_o;
    logic [31:0]   gpio_e;
    logic [31:0]   gpio_i;
    logic          irq;

    int            testCount = 0;
    int            failCount = 0;

    // Reference model state: register contents plus the pin value sampled at every clock edge since reset.
    logic [31:0]   mOut, mOe, mIen, mRise, mFall, mStatus, mRdt;
    logic [31:0]   pinHist [0:4095];
    int            edgeNum;
    logic [31:0]   curPins;

    r5p_soc_gpio_irq #(.GW(GW), .SW(SW), .DW(DW), .AW(AW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus_vld_i (bus_vld),
        .bus_wen_i (bus_wen),
        .bus_adr_i (bus_adr),
        .bus_ben_i (bus_ben),
        .bus_wdt_i (bus_wdt),
        .bus_rdt_o (bus_rdt),
        .bus_rdy_o (bus_rdy),
        .gpio_o    (gpio_o),
        .gpio_e_o  (gpio_e),
        .gpio_i    (gpio_i),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] getPin(input int k);
        return (k < 1) ? 32'h0 : pinHist[k];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The synchronized value seen just before edge n is the pin sampled SW edges earlier.
    task automatic modelEdge(input logic vld, input logic wen, input logic [AW-1:0] adr,
                             input logic [3:0] ben, input logic [31:0] wdt, input logic [31:0] pins);
        logic [31:0] msk, wd, cur, old, capt, w1c;
        int          idx;
        edgeNum++;
        pinHist[edgeNum] = pins;
        idx  = int'(adr[AW-1:2]);
        msk  = {{8{ben[3]}}, {8{ben[2]}}, {8{ben[1]}}, {8{ben[0]}}};
        wd   = wdt & msk;
        cur  = getPin(edgeNum - SW);
        old  = getPin(edgeNum - SW - 1);
        capt = (edgeNum > SW + 1) ? (((cur & ~old) & mRise) | ((~cur & old) & mFall)) : 32'h0;
        w1c  = 32'h0;
        if (vld && !wen) begin
            case (idx)
                0:       mRdt = mOut;
                1:       mRdt = mOe;
                2:       mRdt = cur;
                5:       mRdt = mIen;
                6:       mRdt = mRise;
                7:       mRdt = mFall;
                8:       mRdt = mStatus;
                default: mRdt = 32'h0;
            endcase
        end
        if (vld && wen) begin
            case (idx)
                0:       mOut  = (mOut & ~msk) | wd;
                1:       mOe   = (mOe & ~msk) | wd;
                3:       mOut  = mOut | wd;
                4:       mOut  = mOut & ~wd;
                5:       mIen  = (mIen & ~msk) | wd;
                6:       mRise = (mRise & ~msk) | wd;
                7:       mFall = (mFall & ~msk) | wd;
                8:       w1c   = wd;
                default: ;
            endcase
        end
        mStatus = (mStatus & ~w1c) | capt;
    endtask

    task automatic checkOutput();
        check("rdt", bus_rdt, mRdt);
        check("gpio_o", gpio_o, mOut);
        check("gpio_e", gpio_e, mOe);
        check("irq", {31'b0, irq}, {31'b0, |(mStatus & mIen)});
    endtask

    task automatic applyStimulus(input logic vld, input logic wen, input logic [AW-1:0] adr,
                                 input logic [3:0] ben, input logic [31:0] wdt);
        bus_vld = vld;
        bus_wen = wen;
        bus_adr = adr;
        bus_ben = ben;
        bus_wdt = wdt;
        gpio_i  = curPins;
        modelEdge(vld, wen, adr, ben, wdt, curPins);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic busWrite(input logic [AW-1:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
        applyStimulus(1'b1, 1'b1, adr, ben, wdt);
    endtask

    task automatic busRead(input logic [AW-1:0] adr);
        applyStimulus(1'b1, 1'b0, adr, 4'hF, 32'h0);
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        mOut    = 32'h0;
        mOe     = 32'h0;
        mIen    = 32'h0;
        mRise   = 32'h0;
        mFall   = 32'h0;
        mStatus = 32'h0;
        mRdt    = 32'h0;
        edgeNum = 0;
        @(negedge clk);
        check("rst_rdt", bus_rdt, 32'h0);
        check("rst_gpio_o", gpio_o, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_rdy", {31'b0, bus_rdy}, 32'h1);
        bus_vld = 1'b0;
        bus_wen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]    w;
        logic [AW-1:0] adr;
        rst_n   = 1'b0;
        bus_vld = 1'b0;
        bus_wen = 1'b0;
        bus_adr = '0;
        bus_ben = 4'h0;
        bus_wdt = 32'h0;
        curPins = 32'hFFFF_FFFF;
        gpio_i  = curPins;

        // Pins high through reset must not produce rise events.
        doReset();
        idle(SW);
        busRead(6'h08);
        check("t1_in", bus_rdt, 32'hFFFF_FFFF);
        idle(3);
        busRead(6'h20);
        check("t1_status", bus_rdt, 32'h0);
        check("t1_irq", {31'b0, irq}, 32'h0);

        busWrite(6'h00, 4'hF, 32'h0000_00F0);
        check("t2_out", gpio_o, 32'h0000_00F0);
        busWrite(6'h0C, 4'hF, 32'h0000_000F);
        check("t2_set", gpio_o, 32'h0000_00FF);
        busWrite(6'h10, 4'hF, 32'h0000_0030);
        check("t2_clr", gpio_o, 32'h0000_00CF);
        busRead(6'h00);
        check("t2_read", bus_rdt, 32'h0000_00CF);
        busRead(6'h0C);
        check("t2_setrd", bus_rdt, 32'h0);

        busWrite(6'h04, 4'hF, 32'h0);
        busWrite(6'h04, 4'b0010, 32'hAAAA_AAAA);
        busRead(6'h04);
        check("t3_oe", bus_rdt, 32'h0000_AA00);

        curPins = 32'h0;
        idle(SW + 2);
        busWrite(6'h18, 4'hF, 32'h1);
        busWrite(6'h14, 4'hF, 32'h1);
        curPins = 32'h1;
        for (int k = 0; k < SW; k++) begin
            idle(1);
            check("t4_irq_early", {31'b0, irq}, 32'h0);
        end
        idle(1);
        check("t4_irq_set", {31'b0, irq}, 32'h1);
        busRead(6'h20);
        check("t4_status", bus_rdt, 32'h1);
        busWrite(6'h20, 4'hF, 32'h1);
        check("t4_irq_clr", {31'b0, irq}, 32'h0);
        busRead(6'h20);
        check("t4_status_clr", bus_rdt, 32'h0);

        busWrite(6'h14, 4'hF, 32'h0);
        curPins = 32'h3;
        idle(SW + 2);
        busWrite(6'h1C, 4'hF, 32'h2);
        curPins = 32'h1;
        idle(SW + 1);
        busRead(6'h20);
        check("t5_status", bus_rdt, 32'h2);
        check("t5_irq_off", {31'b0, irq}, 32'h0);
        busWrite(6'h14, 4'hF, 32'h2);
        check("t5_irq_on", {31'b0, irq}, 32'h1);

        busWrite(6'h20, 4'hF, 32'hFFFF_FFFF);
        curPins = 32'h0;
        idle(SW + 2);
        curPins = 32'h1;
        idle(SW);
        busWrite(6'h20, 4'hF, 32'h1);
        busRead(6'h20);
        check("t6_set_wins", bus_rdt, 32'h1);

        // Reset lands while a write is on the bus and read data is held.
        busRead(6'h00);
        check("t7_pre", bus_rdt, 32'h0000_00CF);
        bus_vld = 1'b1;
        bus_wen = 1'b1;
        bus_adr = 6'h00;
        bus_ben = 4'hF;
        bus_wdt = 32'hFFFF_FFFF;
        curPins = $urandom;
        gpio_i  = curPins;
        doReset();
        busRead(6'h00);
        check("t7_out", bus_rdt, 32'h0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) curPins = curPins ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) w = 4'($urandom_range(9, 15));
            else                           w = 4'($urandom_range(0, 8));
            adr = {w, 2'($urandom_range(0, 3))};
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), adr,
                          4'($urandom_range(0, 15)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
